// File: rtl/cp0_int_ctrl_if.sv
// Pipeline <-> CP0 interrupt controller bundle.
// master: pipeline/bridge side. It drives the interrupt lines, the commit-stage
//         info and the mfc0/mtc0/eret controls.
// slave:  cp0_int_ctrl. It returns IntReq, EPC and the mfc0 read data.
interface cp0_int_ctrl_if;
    logic [5:0]  HW_INT;
    logic [31:0] PC;
    logic [4:0]  ExcCode;
    logic        BD;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    modport master (
        output HW_INT, PC, ExcCode, BD, A1, A2, DIn, We, EXLClr,
        input  IntReq, EPC, DOut
    );

    modport slave (
        input  HW_INT, PC, ExcCode, BD, A1, A2, DIn, We, EXLClr,
        output IntReq, EPC, DOut
    );
endinterface

// File: rtl/cp0_int_ctrl.sv
// Coprocessor-0 interrupt/exception controller.
// Holds SR(12), Cause(13), EPC(14) and PRId(15). It masks and prioritises the
// device interrupt lines and synchronous exceptions into one IntReq. It also
// services mfc0 reads (A1 -> DOut), mtc0 writes (We/A2/DIn) and eret (EXLClr).
// Ports: clk, reset (sync, active-high), bus (cp0_int_ctrl_if.slave).
// IntReq and DOut are combinational. EPC is a register output.
// Optional feature macro: CP0_BD_EN enables branch-delay-slot handling:
// EPC <= PC-4 and Cause.BD when BD=1.
module cp0_int_ctrl #(
    parameter logic [31:0] PRID = 32'h4D49_5053
) (
    input  logic            clk,
    input  logic            reset,
    cp0_int_ctrl_if.slave   bus
);
    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_SR    = REG_W'(12);
    localparam logic [REG_W-1:0] REG_CAUSE = REG_W'(13);
    localparam logic [REG_W-1:0] REG_EPC   = REG_W'(14);
    localparam logic [REG_W-1:0] REG_PRID  = REG_W'(15);

    logic [5:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic [5:0]  ip_q;
    logic [4:0]  code_q;
    logic        bd_q;
    logic [29:0] epc_q;

    logic        int_pend;
    logic        exc_pend;
    logic        int_req;
    logic [29:0] epc_cap;
    logic        bd_cap;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic [31:0] epc_word;

    // Request qualification: interrupts are masked by IM/IE, and everything is blocked by EXL.
    assign int_pend = (|(bus.HW_INT & im_q)) & ie_q & ~exl_q;
    assign exc_pend = (bus.ExcCode != 5'd0) & ~exl_q;
    assign int_req  = int_pend | exc_pend;

`ifdef CP0_BD_EN
    // A delay-slot instruction restarts at its branch, one word earlier.
    logic [31:0] pc_adj;
    logic        unused_pc;
    assign pc_adj    = bus.BD ? (bus.PC - 32'd4) : bus.PC;
    assign epc_cap   = pc_adj[31:2];
    assign bd_cap    = bus.BD;
    assign unused_pc = ^{bus.PC[1:0], pc_adj[1:0]};
`else
    logic unused_pc;
    assign epc_cap   = bus.PC[31:2];
    assign bd_cap    = 1'b0;
    assign unused_pc = ^{bus.PC[1:0], bus.BD};
`endif

    assign sr_word    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_word = {bd_q, 15'd0, ip_q, 3'd0, code_q, 2'd0};
    assign epc_word   = {epc_q, 2'b00};

    assign bus.IntReq = int_req;
    assign bus.EPC    = epc_word;

    // mfc0 read mux (no bypass of a same-cycle mtc0)
    always_comb begin
        bus.DOut = 32'd0;
        case (bus.A1)
            REG_SR:    bus.DOut = sr_word;
            REG_CAUSE: bus.DOut = cause_word;
            REG_EPC:   bus.DOut = epc_word;
            REG_PRID:  bus.DOut = PRID;
            default:   bus.DOut = 32'd0;
        endcase
    end

    // Register update: exception capture overrides (flushes) any mtc0/eret in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q   <= 6'd0;
            exl_q  <= 1'b0;
            ie_q   <= 1'b0;
            ip_q   <= 6'd0;
            code_q <= 5'd0;
            bd_q   <= 1'b0;
            epc_q  <= 30'd0;
        end else begin
            ip_q <= bus.HW_INT;
            if (int_req) begin
                exl_q  <= 1'b1;
                code_q <= int_pend ? 5'd0 : bus.ExcCode;
                epc_q  <= epc_cap;
                bd_q   <= bd_cap;
            end else begin
                if (bus.We) begin
                    if (bus.A2 == REG_SR) begin
                        im_q  <= bus.DIn[15:10];
                        exl_q <= bus.DIn[1];
                        ie_q  <= bus.DIn[0];
                    end else if (bus.A2 == REG_EPC) begin
                        epc_q <= bus.DIn[31:2];
                    end
                end
                // eret outranks an mtc0 to SR for the EXL bit only
                if (bus.EXLClr) begin
                    exl_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Self-checking bench for cp0_int_ctrl: directed scenarios plus a randomized
// run checked against a word-level model of SR/Cause/EPC.
module tb_cp0_int_ctrl;
    localparam logic [31:0] PRID = 32'h4D49_5053;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    cp0_int_ctrl_if bus ();

    cp0_int_ctrl #(.PRID(PRID)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.A1 = a;
        #1;
        d = bus.DOut;
    endtask

    task automatic idle_inputs();
        bus.HW_INT = 6'd0; bus.PC = 32'd0; bus.ExcCode = 5'd0; bus.BD = 1'b0;
        bus.A1 = 5'd0; bus.A2 = 5'd0; bus.DIn = 32'd0; bus.We = 1'b0; bus.EXLClr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic write_sr(input logic [31:0] v);
        bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = v;
        step();
        bus.We = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        rd(5'd12, d);
        total++; if (d !== 32'd0) $display("FAIL reset_sr: got %h want %h", d, 32'd0); else passed++;
        rd(5'd13, d);
        total++; if (d !== 32'd0) $display("FAIL reset_cause: got %h want %h", d, 32'd0); else passed++;
        rd(5'd14, d);
        total++; if (d !== 32'd0) $display("FAIL reset_epc_rd: got %h want %h", d, 32'd0); else passed++;
        rd(5'd15, d);
        total++; if (d !== 32'h4D49_5053) $display("FAIL reset_prid: got %h want %h", d, 32'h4D49_5053); else passed++;
        total++; if (bus.IntReq !== 1'b0) $display("FAIL reset_intreq: got %b want 0", bus.IntReq); else passed++;
        total++; if (bus.EPC !== 32'd0) $display("FAIL reset_epc_port: got %h want %h", bus.EPC, 32'd0); else passed++;
    endtask

    task automatic test_int_take();
        logic [31:0] d;
        do_reset();
        write_sr(32'h0000_0401);
        bus.HW_INT = 6'b000001; bus.PC = 32'h0000_3010;
        #1;
        total++; if (bus.IntReq !== 1'b1) $display("FAIL int_req_same_cycle: got %b want 1", bus.IntReq); else passed++;
        step();
        rd(5'd12, d);
        total++; if (d !== 32'h0000_0403) $display("FAIL int_sr: got %h want %h", d, 32'h0000_0403); else passed++;
        rd(5'd14, d);
        total++; if (d !== 32'h0000_3010) $display("FAIL int_epc: got %h want %h", d, 32'h0000_3010); else passed++;
        rd(5'd13, d);
        total++; if (d !== 32'h0000_0400) $display("FAIL int_cause: got %h want %h", d, 32'h0000_0400); else passed++;
        total++; if (bus.IntReq !== 1'b0) $display("FAIL int_req_drop: got %b want 0", bus.IntReq); else passed++;
    endtask

    // Follows test_int_take: EXL=1 with HW_INT[0] still held.
    task automatic test_eret_rearm();
        logic [31:0] d;
        bus.EXLClr = 1'b1;
        step();
        bus.EXLClr = 1'b0;
        #1;
        total++; if (bus.IntReq !== 1'b1) $display("FAIL eret_rearm_req: got %b want 1", bus.IntReq); else passed++;
        rd(5'd12, d);
        total++; if (d !== 32'h0000_0401) $display("FAIL eret_sr: got %h want %h", d, 32'h0000_0401); else passed++;
        // mtc0 EPC together with IntReq is flushed; EPC recaptures PC instead
        bus.We = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'hDEAD_BEE0;
        step();
        bus.We = 1'b0;
        rd(5'd14, d);
        total++; if (d !== 32'h0000_3010) $display("FAIL we_dropped_epc: got %h want %h", d, 32'h0000_3010); else passed++;
        // mtc0 SR with eret: EXL is cleared, IM/IE come from DIn
        bus.HW_INT = 6'd0;
        bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'hFFFF_FC03; bus.EXLClr = 1'b1;
        step();
        bus.We = 1'b0; bus.EXLClr = 1'b0;
        rd(5'd12, d);
        total++; if (d !== 32'h0000_FC01) $display("FAIL we_exlclr_sr: got %h want %h", d, 32'h0000_FC01); else passed++;
    endtask

    task automatic test_masked();
        logic [31:0] d;
        do_reset();
        write_sr(32'h0000_0801);
        bus.HW_INT = 6'b000001;
        #1;
        total++; if (bus.IntReq !== 1'b0) $display("FAIL masked_req: got %b want 0", bus.IntReq); else passed++;
        step();
        rd(5'd13, d);
        total++; if (d !== 32'h0000_0400) $display("FAIL masked_cause: got %h want %h", d, 32'h0000_0400); else passed++;
        total++; if (bus.IntReq !== 1'b0) $display("FAIL masked_req_after: got %b want 0", bus.IntReq); else passed++;
    endtask

    task automatic test_exception();
        logic [31:0] d;
        do_reset();
        bus.ExcCode = 5'd10; bus.PC = 32'h0000_3020;
        #1;
        total++; if (bus.IntReq !== 1'b1) $display("FAIL exc_req: got %b want 1", bus.IntReq); else passed++;
        step();
        bus.ExcCode = 5'd0;
        rd(5'd13, d);
        total++; if (d !== 32'h0000_0028) $display("FAIL exc_cause: got %h want %h", d, 32'h0000_0028); else passed++;
        total++; if (bus.EPC !== 32'h0000_3020) $display("FAIL exc_epc: got %h want %h", bus.EPC, 32'h0000_3020); else passed++;
    endtask

    task automatic test_bd();
        logic [31:0] d;
        logic [31:0] exp_epc;
        logic [31:0] exp_bit;
`ifdef CP0_BD_EN
        exp_epc = 32'h0000_3004; exp_bit = 32'h8000_0000;
`else
        exp_epc = 32'h0000_3008; exp_bit = 32'h0000_0000;
`endif
        do_reset();
        write_sr(32'h0000_0401);
        bus.HW_INT = 6'b000001; bus.BD = 1'b1; bus.PC = 32'h0000_3008;
        step();
        bus.BD = 1'b0;
        rd(5'd14, d);
        total++; if (d !== exp_epc) $display("FAIL bd_epc: got %h want %h", d, exp_epc); else passed++;
        rd(5'd13, d);
        total++; if ((d & 32'h8000_0000) !== exp_bit) $display("FAIL bd_cause31: got %h want %h", d & 32'h8000_0000, exp_bit); else passed++;
    endtask

    task automatic test_mid_reset();
        logic [31:0] d;
        do_reset();
        write_sr(32'h0000_0401);
        bus.HW_INT = 6'b000001; bus.PC = 32'h0000_3010;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.HW_INT = 6'd0;
        rd(5'd12, d);
        total++; if (d !== 32'd0) $display("FAIL midreset_sr: got %h want %h", d, 32'd0); else passed++;
        total++; if (bus.EPC !== 32'd0) $display("FAIL midreset_epc: got %h want %h", bus.EPC, 32'd0); else passed++;
    endtask

    // Random traffic against a word-level model built from the register layout rules.
    task automatic test_random();
        logic [31:0] m_sr, m_cause, m_epc;
        logic [31:0] n_sr, n_cause, n_epc;
        logic [31:0] exp_dout;
        logic        ipend, epend, req, rst_now;
        logic [4:0]  regs [6];
        regs[0] = 5'd12; regs[1] = 5'd13; regs[2] = 5'd14; regs[3] = 5'd15; regs[4] = 5'd0; regs[5] = 5'd31;
        do_reset();
        m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
        for (int i = 0; i < 2000; i++) begin
            rst_now     = ($urandom_range(0, 99) == 0);
            bus.HW_INT  = 6'($urandom_range(0, 3) == 0 ? $urandom : 0);
            bus.ExcCode = 5'($urandom_range(0, 5) == 0 ? $urandom_range(1, 31) : 0);
            bus.BD      = 1'($urandom);
            bus.PC      = {30'($urandom), 2'b00};
            bus.A1      = regs[$urandom_range(0, 5)];
            bus.A2      = ($urandom_range(0, 1) == 0) ? 5'd12 : regs[$urandom_range(0, 5)];
            bus.DIn     = $urandom;
            bus.We      = 1'($urandom);
            bus.EXLClr  = ($urandom_range(0, 3) == 0);
            reset       = rst_now;
            #1;
            ipend = ((bus.HW_INT & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
            epend = (bus.ExcCode != 5'd0) && !m_sr[1];
            req   = ipend || epend;
            case (bus.A1)
                5'd12:   exp_dout = m_sr;
                5'd13:   exp_dout = m_cause;
                5'd14:   exp_dout = m_epc;
                5'd15:   exp_dout = PRID;
                default: exp_dout = 32'd0;
            endcase
            total++; if (bus.IntReq !== req) $display("FAIL rand_intreq[%0d]: got %b want %b", i, bus.IntReq, req); else passed++;
            total++; if (bus.DOut !== exp_dout) $display("FAIL rand_dout[%0d] a1=%0d: got %h want %h", i, bus.A1, bus.DOut, exp_dout); else passed++;
            total++; if (bus.EPC !== m_epc) $display("FAIL rand_epc[%0d]: got %h want %h", i, bus.EPC, m_epc); else passed++;
            n_sr = m_sr; n_cause = m_cause; n_epc = m_epc;
            if (rst_now) begin
                n_sr = 32'd0; n_cause = 32'd0; n_epc = 32'd0;
            end else begin
                n_cause[15:10] = bus.HW_INT;
                if (req) begin
                    n_sr[1] = 1'b1;
                    n_cause[6:2] = ipend ? 5'd0 : bus.ExcCode;
`ifdef CP0_BD_EN
                    n_epc = bus.BD ? bus.PC - 32'd4 : bus.PC;
                    n_cause[31] = bus.BD;
`else
                    n_epc = bus.PC;
`endif
                end else begin
                    if (bus.We && bus.A2 == 5'd12) n_sr = bus.DIn & 32'h0000_FC03;
                    if (bus.We && bus.A2 == 5'd14) n_epc = bus.DIn & 32'hFFFF_FFFC;
                    if (bus.EXLClr) n_sr[1] = 1'b0;
                end
            end
            step();
            m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        total = 0;
        passed = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_int_take();
        test_eret_rearm();
        test_masked();
        test_exception();
        test_bd();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
